// File: rtl/gaussian_noise_sched_pkg.sv
// Shared constants and types for the Gaussian noise scheduler.
package gaussian_noise_sched_pkg;

    // Width of a channel index on every port and inside the tag pipeline.
    localparam int CHAN_W = 4;

    // Tag carried alongside each grant until its sample returns from the model.
    typedef struct packed {
        logic              valid;
        logic [CHAN_W-1:0] chan;
    } tag_t;

    // Reset values.
    localparam tag_t              TAG_RST  = '{valid: 1'b0, chan: 4'd0};
    localparam logic [CHAN_W-1:0] CHAN_RST = 4'd0;

endpackage

// File: rtl/gaussian_noise_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr_i and wraps at N-1 -> 0.
module rr_arbiter
    import gaussian_noise_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]      req_i,
    input  logic [CHAN_W-1:0] ptr_i,
    output logic [N-1:0]      gnt_o,
    output logic [CHAN_W-1:0] win_o,
    output logic              valid_o
);

    localparam logic [N-1:0] ONE_HOT_LSB = {{(N-1){1'b0}}, 1'b1};

    logic [CHAN_W:0] idx_s;
    logic [N-1:0]    req_sh_s;
    logic            found_s;

    // Walk the channels from the pointer and keep the first requester seen.
    always_comb begin
        found_s  = 1'b0;
        win_o    = '0;
        idx_s    = '0;
        req_sh_s = '0;
        for (int i = 0; i < N; i++) begin
            idx_s = {1'b0, ptr_i} + (CHAN_W+1)'(i);
            if (idx_s >= (CHAN_W+1)'(N)) begin
                idx_s = idx_s - (CHAN_W+1)'(N);
            end else begin
                idx_s = idx_s;
            end
            req_sh_s = req_i >> idx_s;
            if (!found_s && req_sh_s[0]) begin
                found_s = 1'b1;
                win_o   = idx_s[CHAN_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
        valid_o = found_s;
        if (found_s) begin
            gnt_o = ONE_HOT_LSB << win_o;
        end else begin
            gnt_o = '0;
        end
    end

endmodule

// File: rtl/gaussian_noise_sched.sv
// Shares one Gaussian noise model among N_CHAN channels: round-robin grant,
// per-channel mean/std table, and a tag pipeline matching the model latency.
module gaussian_noise_sched
    import gaussian_noise_sched_pkg::*;
#(
    parameter int N_CHAN = 4,
    parameter int WIDTH  = 18,
    parameter int LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CHAN-1:0]    req,
    output logic [N_CHAN-1:0]    gnt,
    input  logic                 cfg_we,
    input  logic [CHAN_W-1:0]    cfg_addr,
    input  logic [WIDTH-1:0]     cfg_mean,
    input  logic [WIDTH-1:0]     cfg_std,
    output logic [WIDTH-1:0]     mean_out,
    output logic [WIDTH-1:0]     std_out,
    input  logic [WIDTH-1:0]     noise_in,
    output logic                 smp_valid,
    output logic [CHAN_W-1:0]    smp_chan,
    output logic [WIDTH-1:0]     smp_data
);

    logic [N_CHAN-1:0] arb_gnt_s;
    logic [CHAN_W-1:0] arb_win_s;
    logic              arb_valid_s;
    logic [CHAN_W-1:0] ptr_q;
    logic [CHAN_W-1:0] ptr_d;
    logic [WIDTH-1:0]  mean_tab_q [N_CHAN];
    logic [WIDTH-1:0]  std_tab_q  [N_CHAN];
    logic [WIDTH-1:0]  sel_mean_s;
    logic [WIDTH-1:0]  sel_std_s;
    tag_t              cur_tag_q;
    tag_t              tag_q [LAT];

    rr_arbiter #(.N(N_CHAN)) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt_s),
        .win_o   (arb_win_s),
        .valid_o (arb_valid_s)
    );

    // Next pointer is one past the winner (mod N_CHAN); unchanged when idle.
    always_comb begin
        ptr_d = ptr_q;
        if (arb_valid_s) begin
            if (arb_win_s == CHAN_W'(N_CHAN - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = arb_win_s + 4'd1;
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Read the winner's settings from the table (pre-write value this cycle).
    always_comb begin
        sel_mean_s = '0;
        sel_std_s  = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            if (arb_win_s == CHAN_W'(c)) begin
                sel_mean_s = mean_tab_q[c];
                sel_std_s  = std_tab_q[c];
            end else begin
                sel_mean_s = sel_mean_s;
            end
        end
    end

    // Configuration table; out-of-range addresses match no entry and are dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < N_CHAN; c++) begin
                mean_tab_q[c] <= '0;
                std_tab_q[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < N_CHAN; c++) begin
                if (cfg_we && (cfg_addr == CHAN_W'(c))) begin
                    mean_tab_q[c] <= cfg_mean;
                    std_tab_q[c]  <= cfg_std;
                end
            end
        end
    end

    // Register grant, model drive values and pointer; mean/std hold when idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt      <= '0;
            mean_out <= '0;
            std_out  <= '0;
            ptr_q    <= CHAN_RST;
        end else begin
            gnt   <= arb_gnt_s;
            ptr_q <= ptr_d;
            if (arb_valid_s) begin
                mean_out <= sel_mean_s;
                std_out  <= sel_std_s;
            end
        end
    end

    // Tag follows the registered grant through LAT stages, then tags the sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_tag_q <= TAG_RST;
            for (int k = 0; k < LAT; k++) begin
                tag_q[k] <= TAG_RST;
            end
            smp_valid <= 1'b0;
            smp_chan  <= CHAN_RST;
            smp_data  <= '0;
        end else begin
            cur_tag_q <= '{valid: arb_valid_s, chan: arb_win_s};
            tag_q[0]  <= cur_tag_q;
            for (int k = 1; k < LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            smp_valid <= tag_q[LAT-1].valid;
            if (tag_q[LAT-1].valid) begin
                smp_chan <= tag_q[LAT-1].chan;
                smp_data <= noise_in;
            end
        end
    end

endmodule

// File: tb/tb_gaussian_noise_sched.sv
// Directed bench for gaussian_noise_sched: instance A has LAT=1, instance B LAT=4.
module tb_gaussian_noise_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [17:0] cfg_mean;
    logic [17:0] cfg_std;
    logic [17:0] noise;

    logic [3:0]  gnt_a, gnt_b;
    logic [17:0] mean_a, mean_b, std_a, std_b;
    logic        sv_a, sv_b;
    logic [3:0]  sc_a, sc_b;
    logic [17:0] sd_a, sd_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gaussian_noise_sched #(.N_CHAN(4), .WIDTH(18), .LAT(1)) dut_a (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_a),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mean(cfg_mean), .cfg_std(cfg_std),
        .mean_out(mean_a), .std_out(std_a), .noise_in(noise),
        .smp_valid(sv_a), .smp_chan(sc_a), .smp_data(sd_a)
    );

    gaussian_noise_sched #(.N_CHAN(4), .WIDTH(18), .LAT(4)) dut_b (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_b),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mean(cfg_mean), .cfg_std(cfg_std),
        .mean_out(mean_b), .std_out(std_b), .noise_in(noise),
        .smp_valid(sv_b), .smp_chan(sc_b), .smp_data(sd_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 4'b0000; cfg_we = 1'b0; cfg_addr = 4'd0;
        cfg_mean = 18'h0; cfg_std = 18'h0; noise = 18'h0;
        repeat (3) tick();
        rst = 1'b1;
        total++; if (gnt_a !== 4'b0000) begin bad++; $display("FAIL reset_gnt_a: got %b exp 0000", gnt_a); end
        total++; if (mean_a !== 18'h0) begin bad++; $display("FAIL reset_mean_a: got %h exp 0", mean_a); end
        total++; if (std_a !== 18'h0) begin bad++; $display("FAIL reset_std_a: got %h exp 0", std_a); end
        total++; if ({sv_a, sc_a, sd_a} !== 23'h0) begin bad++; $display("FAIL reset_smp_a: got v=%b c=%h d=%h exp 0", sv_a, sc_a, sd_a); end
        total++; if ({gnt_b, mean_b, std_b} !== 40'h0) begin bad++; $display("FAIL reset_b: got g=%b m=%h s=%h exp 0", gnt_b, mean_b, std_b); end
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if ({sv_a, sv_b, gnt_a} !== 6'b0) begin
                bad++; $display("FAIL idle_cycle%0d: got va=%b vb=%b gnt=%b exp all 0", i, sv_a, sv_b, gnt_a);
            end
        end
    endtask

    task automatic test_single_channel();
        cfg_we = 1'b1; cfg_addr = 4'd2; cfg_mean = 18'h00100; cfg_std = 18'h00040;
        tick();
        cfg_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req = 4'b0100;
            noise = 18'h00A00 + 18'(i);
            tick();
            total++; if (gnt_a !== 4'b0100) begin bad++; $display("FAIL single_gnt%0d: got %b exp 0100", i, gnt_a); end
            total++; if ({mean_a, std_a} !== {18'h00100, 18'h00040}) begin bad++; $display("FAIL single_cfg%0d: got m=%h s=%h exp 100/040", i, mean_a, std_a); end
            if (i < 2) begin
                total++; if (sv_a !== 1'b0) begin bad++; $display("FAIL single_early%0d: got valid %b exp 0", i, sv_a); end
            end else begin
                total++;
                if ({sv_a, sc_a, sd_a} !== {1'b1, 4'd2, 18'h00A00 + 18'(i)}) begin
                    bad++; $display("FAIL single_smp%0d: got v=%b c=%0d d=%h exp v=1 c=2 d=%h", i, sv_a, sc_a, sd_a, 18'h00A00 + 18'(i));
                end
            end
        end
        // Idle cycle: no grant, drive values hold, pointer stays at 3.
        req = 4'b0000;
        tick();
        total++; if (gnt_a !== 4'b0000) begin bad++; $display("FAIL hold_gnt: got %b exp 0000", gnt_a); end
        total++; if ({mean_a, std_a} !== {18'h00100, 18'h00040}) begin bad++; $display("FAIL hold_cfg: got m=%h s=%h exp 100/040", mean_a, std_a); end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_g [3];
        exp_g[0] = 4'b1000; exp_g[1] = 4'b0001; exp_g[2] = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            req = 4'b1001;
            tick();
            total++; if (gnt_a !== exp_g[i]) begin bad++; $display("FAIL wrap_gnt%0d: got %b exp %b", i, gnt_a, exp_g[i]); end
        end
    endtask

    task automatic test_fairness();
        logic [3:0] eg;
        for (int j = 0; j < 12; j++) begin
            req = 4'b1111;
            noise = 18'h01000 + 18'(j);
            tick();
            eg = 4'b0001 << (j % 4);
            total++; if (gnt_a !== eg) begin bad++; $display("FAIL fair_gnt%0d: got %b exp %b", j, gnt_a, eg); end
            total++; if (gnt_b !== eg) begin bad++; $display("FAIL fair_gnt_b%0d: got %b exp %b", j, gnt_b, eg); end
            if (j >= 2) begin
                total++;
                if ({sv_a, sc_a, sd_a} !== {1'b1, 4'((j - 2) % 4), 18'h01000 + 18'(j)}) begin
                    bad++; $display("FAIL fair_smp%0d: got v=%b c=%0d d=%h exp v=1 c=%0d", j, sv_a, sc_a, sd_a, (j - 2) % 4);
                end
            end
        end
        req = 4'b0000;
        for (int j = 0; j < 3; j++) begin
            tick();
            total++;
            if (j < 2) begin
                if ({sv_a, sc_a} !== {1'b1, 4'(2 + j)}) begin bad++; $display("FAIL fair_tail%0d: got v=%b c=%0d exp v=1 c=%0d", j, sv_a, sc_a, 2 + j); end
            end else begin
                if (sv_a !== 1'b0) begin bad++; $display("FAIL fair_end: got valid %b exp 0", sv_a); end
            end
        end
    endtask

    task automatic test_cfg_collision();
        cfg_we = 1'b1; cfg_addr = 4'd1; cfg_mean = 18'h00200; cfg_std = 18'h00011; req = 4'b0000;
        tick();
        // Write ch1 in the same edge ch1 is granted.
        req = 4'b0010; cfg_addr = 4'd1; cfg_mean = 18'h00300; cfg_std = 18'h00022;
        tick();
        total++; if (gnt_a !== 4'b0010) begin bad++; $display("FAIL coll_gnt: got %b exp 0010", gnt_a); end
        total++; if ({mean_a, std_a} !== {18'h00200, 18'h00011}) begin bad++; $display("FAIL coll_old: got m=%h s=%h exp 200/011", mean_a, std_a); end
        // Out-of-range address write while ch1 is granted again.
        cfg_addr = 4'd5; cfg_mean = 18'h3FFFF; cfg_std = 18'h01234;
        tick();
        total++; if ({mean_a, std_a} !== {18'h00300, 18'h00022}) begin bad++; $display("FAIL coll_new: got m=%h s=%h exp 300/022", mean_a, std_a); end
        cfg_we = 1'b0;
        tick();
        total++; if ({mean_a, std_a} !== {18'h00300, 18'h00022}) begin bad++; $display("FAIL addr5_ch1: got m=%h s=%h exp 300/022", mean_a, std_a); end
        req = 4'b0100;
        tick();
        total++; if ({mean_a, std_a} !== {18'h00100, 18'h00040}) begin bad++; $display("FAIL addr5_ch2: got m=%h s=%h exp 100/040", mean_a, std_a); end
        req = 4'b0001;
        tick();
        total++; if ({gnt_a, mean_a, std_a} !== {4'b0001, 36'h0}) begin bad++; $display("FAIL addr5_ch0: got g=%b m=%h s=%h exp 0001/0/0", gnt_a, mean_a, std_a); end
        req = 4'b1000;
        tick();
        total++; if ({gnt_a, mean_a, std_a} !== {4'b1000, 36'h0}) begin bad++; $display("FAIL addr5_ch3: got g=%b m=%h s=%h exp 1000/0/0", gnt_a, mean_a, std_a); end
    endtask

    task automatic test_reset_mid();
        logic ev;
        // Pointer is 0 here; grants 0,1,0 leave it at 1 with three samples in flight on B.
        req = 4'b0011;
        noise = 18'h02222;
        repeat (3) tick();
        rst = 1'b0; req = 4'b1001;
        tick();
        rst = 1'b1;
        total++; if ({gnt_b, mean_b, std_b} !== 40'h0) begin bad++; $display("FAIL rmid_b: got g=%b m=%h s=%h exp 0", gnt_b, mean_b, std_b); end
        total++; if ({sv_b, sc_b, sd_b} !== 23'h0) begin bad++; $display("FAIL rmid_smp: got v=%b c=%h d=%h exp 0", sv_b, sc_b, sd_b); end
        tick();
        total++; if (gnt_b !== 4'b0001) begin bad++; $display("FAIL rmid_first_b: got %b exp 0001", gnt_b); end
        total++; if (gnt_a !== 4'b0001) begin bad++; $display("FAIL rmid_first_a: got %b exp 0001", gnt_a); end
        req = 4'b0100; noise = 18'h03333;
        tick();
        total++; if ({gnt_b, mean_b, std_b} !== {4'b0100, 36'h0}) begin bad++; $display("FAIL rmid_tbl: got g=%b m=%h s=%h exp 0100/0/0", gnt_b, mean_b, std_b); end
        total++; if (sv_b !== 1'b0) begin bad++; $display("FAIL rmid_drop1: got valid %b exp 0", sv_b); end
        req = 4'b0000;
        for (int k = 2; k < 8; k++) begin
            noise = 18'h04000 + 18'(k);
            tick();
            ev = (k == 5) || (k == 6);
            total++; if (sv_b !== ev) begin bad++; $display("FAIL rmid_valid%0d: got %b exp %b", k, sv_b, ev); end
            if (ev) begin
                total++;
                if ({sc_b, sd_b} !== {4'((k == 5) ? 0 : 2), 18'h04000 + 18'(k)}) begin
                    bad++; $display("FAIL rmid_smp%0d: got c=%0d d=%h exp c=%0d d=%h", k, sc_b, sd_b, (k == 5) ? 0 : 2, 18'h04000 + 18'(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_wrap();
        test_fairness();
        test_cfg_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
